// File: rtl/query_feeder.sv
// query_feeder: unpacks 2-bit bases from packed query words and pours them,
// one valid-tagged base per cycle, into the downstream query buffer.
module query_feeder #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [LEN_BITS-1:0]  len_i,
    input  logic [WORD_BITS-1:0] word_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    input  logic                 full_i,
    input  logic                 update_i,
    output logic [2:0]           q_o,
    output logic                 pouring_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned BPW     = WORD_BITS / 2;
    localparam int unsigned WL_BITS = $clog2(BPW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_POUR  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [LEN_BITS-1:0]  remain, remain_d;
    logic [WL_BITS-1:0]   word_left, word_left_d;
    logic [WORD_BITS-1:0] shift, shift_d;
    logic                 pouring, pouring_d;
    logic                 emit;

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remain    <= '0;
            word_left <= '0;
            shift     <= '0;
            pouring   <= 1'b0;
        end else begin
            state     <= state_d;
            remain    <= remain_d;
            word_left <= word_left_d;
            shift     <= shift_d;
            pouring   <= pouring_d;
        end
    end

    // Next-state, datapath update and emit decision.
    always_comb begin
        state_d     = state;
        remain_d    = remain;
        word_left_d = word_left;
        shift_d     = shift;
        pouring_d   = 1'b0;
        emit        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    // An empty sequence still pours for one cycle so the buffer marks it.
                    pouring_d = 1'b1;
                    if (len_i != '0) begin
                        remain_d = len_i;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                pouring_d = 1'b1;
                if (word_valid_i) begin
                    shift_d     = word_i;
                    word_left_d = (32'(remain) >= BPW) ? WL_BITS'(BPW) : WL_BITS'(remain);
                    state_d     = S_POUR;
                end
            end
            S_POUR: begin
                pouring_d = 1'b1;
                // A simultaneous pop frees a slot even when the buffer reports full.
                emit = ~full_i | update_i;
                if (emit) begin
                    shift_d     = shift >> 2;
                    remain_d    = remain - LEN_BITS'(1);
                    word_left_d = word_left - WL_BITS'(1);
                    if (remain == LEN_BITS'(1)) begin
                        state_d   = S_DONE;
                        pouring_d = 1'b0;
                    end else if (word_left == WL_BITS'(1)) begin
                        state_d   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register and the emit decision.
    assign word_ready_o = (state == S_FETCH);
    assign q_o          = emit ? {1'b1, shift[1:0]} : 3'b000;
    assign pouring_o    = pouring;
    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);

endmodule

// File: tb/tb_query_feeder.sv
// tb_query_feeder: directed and randomized pours checked against a base-stream model.
module tb_query_feeder;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned LEN_BITS  = 16;
    localparam int unsigned BPW       = WORD_BITS / 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic [LEN_BITS-1:0]  len_i = '0;
    logic [WORD_BITS-1:0] word_i = '0;
    logic                 word_valid_i = 1'b0;
    logic                 full_i = 1'b0;
    logic                 update_i = 1'b0;
    logic                 word_ready_o;
    logic [2:0]           q_o;
    logic                 pouring_o;
    logic                 busy_o;
    logic                 done_o;

    int n_pass   = 0;
    int n_checks = 0;

    logic [WORD_BITS-1:0] words[$];
    logic [1:0]           got[$];
    logic [2:0]           qlog[0:4095];
    int   d, hs, pour_cyc, busy_cyc, ready_cyc, first_ready, drops, bad_q, done_cnt, last_emit, mode;
    logic pour_at_done;
    logic [9:0] packed5;

    query_feeder #(.WORD_BITS(WORD_BITS), .LEN_BITS(LEN_BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .len_i        (len_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .full_i       (full_i),
        .update_i     (update_i),
        .q_o          (q_o),
        .pouring_o    (pouring_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Per-cycle input pattern for the current scenario.
    task automatic drive(input int c);
        start_i      = 1'b0;
        full_i       = 1'b0;
        update_i     = 1'b0;
        word_valid_i = 1'b1;
        case (mode)
            1: full_i = (c >= 3 && c <= 6);
            2: begin
                full_i   = (c >= 3 && c <= 6);
                update_i = (c == 4);
            end
            3: begin
                full_i       = ($urandom_range(0, 2) == 0);
                update_i     = $urandom_range(0, 1) != 0;
                word_valid_i = ($urandom_range(0, 3) != 0);
            end
            4: if (c == 5) begin
                start_i = 1'b1;
                len_i   = LEN_BITS'(1);
            end
            default: ;
        endcase
        word_i = (hs < words.size()) ? words[hs] : WORD_BITS'($urandom);
    endtask

    // Start a sequence and record what the block does until done (or an early stop).
    task automatic pour(input int len, input int stop_after);
        got.delete();
        d = 0; hs = 0; pour_cyc = 0; busy_cyc = 0; ready_cyc = 0; first_ready = 0;
        drops = 0; bad_q = 0; done_cnt = 0; last_emit = 0; pour_at_done = 1'b0;
        start_i = 1'b1; len_i = LEN_BITS'(len);
        word_valid_i = 1'b0; full_i = 1'b0; update_i = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c < 4000; c++) begin
            drive(c);
            @(negedge clk);
            qlog[c] = q_o;
            if (q_o[2]) begin
                got.push_back(q_o[1:0]);
                last_emit = c;
                if (full_i && !update_i) drops++;
            end else if (q_o != 3'b000) begin
                bad_q++;
            end
            if (word_valid_i && word_ready_o) hs++;
            if (word_ready_o) begin
                ready_cyc++;
                if (first_ready == 0) first_ready = c;
            end
            if (pouring_o) pour_cyc++;
            if (busy_o) busy_cyc++;
            if (done_o) begin
                done_cnt++;
                d = c;
                pour_at_done = pouring_o;
            end
            if (stop_after > 0 && got.size() == stop_after) break;
            @(posedge clk); #1;
            if (d != 0) break;
        end
        start_i = 1'b0;
    endtask

    // Compare the recorded run against the expected base stream and cycle rules.
    task automatic verify(input string tag, input int len);
        int bad;
        logic [1:0] exp_b;
        bad = -1;
        check({tag, " timeout"}, 32'(d != 0), 1);
        check({tag, " count"}, got.size(), len);
        for (int i = 0; i < len && i < got.size(); i++) begin
            exp_b = 2'(words[i / BPW] >> (2 * (i % BPW)));
            if (bad < 0 && got[i] !== exp_b) bad = i;
        end
        check({tag, " first bad base idx"}, bad, -1);
        check({tag, " handshakes"}, hs, (len + BPW - 1) / BPW);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " dropped/bad q"}, drops + bad_q, 0);
        check({tag, " pouring cycles"}, pour_cyc, (len == 0) ? 1 : d - 1);
        check({tag, " busy cycles"}, busy_cyc, d);
        check({tag, " pouring at done"}, 32'(pour_at_done), 32'(len == 0));
        if (len > 0) check({tag, " done after last base"}, d, last_emit + 1);
        check({tag, " idle after done"}, 32'(busy_o), 0);
    endtask

    initial begin
        mode = 0;
        #12;
        check("reset q_o", q_o, 0);
        check("reset pouring", pouring_o, 0);
        check("reset ready", word_ready_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // len=5 from one word
        words = '{32'h0000_03E4};
        mode = 0;
        pour(5, 0);
        verify("len5", 5);
        packed5 = (got.size() >= 5) ? {got[4], got[3], got[2], got[1], got[0]} : 10'h0;
        check("len5 stream", packed5, 10'h3E4);
        check("len5 done cycle", d, 7);
        check("len5 ready cycles", ready_cyc, 1);
        check("len5 first ready", first_ready, 1);

        // len=20 across two words with one fetch bubble
        words = '{32'hFFFF_FFFF, 32'h0000_0000};
        pour(20, 0);
        verify("len20", 20);
        check("len20 done cycle", d, 23);
        check("len20 last of word0", qlog[17], 3'b111);
        check("len20 bubble", qlog[18], 3'b000);
        check("len20 first of word1", qlog[19], 3'b100);

        // stall without pop, then stall with one simultaneous pop
        words = '{WORD_BITS'($urandom)};
        mode = 1;
        pour(3, 0);
        verify("stall", 3);
        check("stall done cycle", d, 9);
        check("stall frozen q", qlog[4], 3'b000);
        mode = 2;
        pour(3, 0);
        verify("stall+pop", 3);
        check("stall+pop done cycle", d, 8);
        check("stall+pop emit", 32'(qlog[4][2]), 1);

        // empty sequence
        words.delete();
        mode = 0;
        pour(0, 0);
        verify("len0", 0);
        check("len0 done cycle", d, 1);
        check("len0 ready cycles", ready_cyc, 0);

        // reset in the middle of a pour
        words = '{WORD_BITS'($urandom)};
        pour(16, 7);
        check("abort pre-reset valid", 32'(q_o[2]), 1);
        rst_n = 1'b0;
        #1;
        check("abort q_o", q_o, 0);
        check("abort pouring", pouring_o, 0);
        check("abort ready", word_ready_o, 0);
        check("abort busy", busy_o, 0);
        check("abort done", done_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        words = '{WORD_BITS'($urandom)};
        pour(2, 0);
        verify("post-reset len2", 2);

        // second start while pouring is ignored
        words = '{WORD_BITS'($urandom)};
        mode = 4;
        pour(10, 0);
        verify("restart ignored", 10);
        check("restart done cycle", d, 12);

        // randomized lengths, words, stalls and word gaps
        mode = 3;
        for (int k = 0; k < 12; k++) begin
            int len;
            case (k)
                0: len = 16;
                1: len = 17;
                2: len = 32;
                3: len = 1;
                default: len = int'($urandom_range(1, 70));
            endcase
            words.delete();
            for (int w = 0; w < (len + BPW - 1) / BPW; w++) words.push_back(WORD_BITS'($urandom));
            pour(len, 0);
            verify($sformatf("rand%0d len%0d", k, len), len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/query_feeder.md
# query_feeder

Serializes a packed query sequence (16 two-bit bases per 32-bit word) into a stream of one valid-tagged base per cycle for the query buffer directly downstream. Also drives that buffer's `pouring` strobe. Words arrive from the query memory / host interface over a valid/ready handshake. The block never emits a base the buffer would drop: it stalls on the buffer's full flag unless the buffer is being drained in the same cycle.

## Interface
- `WORD_BITS`, default 32: input word width; bases per word `BPW = WORD_BITS/2`.
- `LEN_BITS`, default 16: width of the sequence-length field.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle request to pour a sequence; ignored unless in IDLE.
- `len_i`  in  LEN_BITS  number of bases in the sequence; latched on an accepted `start_i`.
- `word_i`  in  WORD_BITS  packed bases; base k = `word_i[2k+1:2k]` (LSB first).
- `word_valid_i`  in  1  `word_i` is valid.
- `word_ready_o`  out  1  block accepts `word_i` this cycle.
- `full_i`  in  1  downstream buffer full flag (registered there).
- `update_i`  in  1  downstream consumer pops the buffer this cycle.
- `q_o`  out  3  `{valid, base[1:0]}`; `3'b000` when no base is emitted.
- `pouring_o`  out  1  high while a sequence is being poured.
- `busy_o`  out  1  state != IDLE.
- `done_o`  out  1  one-cycle pulse at end of a sequence.

## Operation
- States: IDLE, FETCH, POUR, DONE. Registers: `remain` (LEN_BITS), `word_left` (0..BPW), `shift` (WORD_BITS), state.
- IDLE, `start_i`=1:
  - `len_i`!=0: `remain<=len_i`, go to FETCH.
  - `len_i`=0: go to DONE. `pouring_o` is high for exactly that DONE cycle, and no valid base is emitted, so the buffer records an empty sequence.
- FETCH: `word_ready_o`=1 (combinational from state). On `word_valid_i & word_ready_o`: `shift<=word_i`, `word_left<=min(BPW, remain)`, go to POUR. No other state asserts `word_ready_o`.
- POUR:
  - `emit = ~full_i | update_i`. `q_o = emit ? {1'b1, shift[1:0]} : 3'b000` (combinational from state, `shift`, `full_i`, `update_i`).
  - On emit: `shift>>=2`, `remain-=1`, `word_left-=1`.
  - After an emit that zeroes `remain`: go to DONE.
  - Otherwise, after an emit that zeroes `word_left`: go to FETCH.
  - Bases beyond `remain` in the final word are discarded.
- DONE: `done_o`=1, go to IDLE next cycle; `start_i` is ignored.
- `pouring_o` is registered: high in FETCH, POUR, and (for `len`=0 only) DONE. Low in IDLE and in DONE for `len`>0.
- `remain` arithmetic is unsigned and never underflows; `len_i` max = 2^LEN_BITS−1.

## Timing
- Reset values: state IDLE; `q_o`=000, `pouring_o`=0, `word_ready_o`=0, `busy_o`=0, `done_o`=0; `remain`/`word_left`/`shift`=0.
- Reset mid-operation aborts the sequence immediately. No partial state survives.
- Event timeline for `start_i` sampled at edge t:
  - t+1: FETCH, `pouring_o`=1, `busy_o`=1.
  - Word accepted at edge t+1 (valid already high): first base on `q_o` in cycle t+2 if not stalled.
- Throughput: one base per cycle in POUR, plus one FETCH bubble per word (no prefetch). Sequence of N bases, never stalled, words always valid: N + ceil(N/BPW) cycles from FETCH entry to DONE.
- Stall: `full_i`=1 and `update_i`=0 gives `q_o`=000 and no state change. `full_i`=1 and `update_i`=1 emits normally (the buffer does a simultaneous get/send).
- Last base emitted in cycle e: DONE in cycle e+1 (`done_o`=1, `pouring_o`=0), IDLE in e+2.
- `word_valid_i` low in FETCH: wait indefinitely, `pouring_o` stays high.
- `start_i` during FETCH/POUR/DONE: ignored, `len_i` not relatched.

## Test plan
- `len`=5, word 0x000003E4, `full_i`=0: `q_o` = 100,101,110,111,111 on five consecutive cycles from t+2, then `done_o` at t+7 with `pouring_o` low, `word_ready_o` high only at t+1.
- `len`=20, words 0xFFFFFFFF then 0x00000000: 16× `q_o`=111, one bubble cycle (FETCH, `q_o`=000), 4× `q_o`=100. Exactly 2 handshakes; `done_o` 1 cycle after the last base.
- `len`=3, `full_i`=1 for 4 cycles in POUR with `update_i`=0: `q_o`=000 and `remain` frozen. Repeat with `update_i`=1 in the second stall cycle: one base is emitted in that cycle. Total valid bases = 3 in both runs.
- `len`=0: `pouring_o` high for exactly one cycle at t+1 with `done_o`=1 in the same cycle, `q_o` never valid, `word_ready_o` never high.
- Reset asserted mid-POUR (after 7 of 16 bases): all outputs 0 asynchronously. After release, a new `start_i` with `len`=2 emits only 2 bases from the new word.
- `start_i` pulsed again during POUR with `len_i`=1: ignored; the original sequence completes with its full base count.
